// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and sizing for the reservation-station issue scheduler.
// Optional feature macro used by the scheduler: RS_WAKEUP_BYPASS_EN.
package rs_issue_scheduler_pkg;

    localparam int RS_ENTRIES = 4;
    localparam int NUM_FUS    = 4;
    localparam int NUM_PREGS  = 64;
    localparam int PW         = $clog2(NUM_PREGS);
    localparam int RS_IDX_W   = $clog2(RS_ENTRIES);
    localparam int RS_CNT_W   = $clog2(RS_ENTRIES + 1);
    localparam int XLEN       = 32;

    typedef enum logic {
        REG_FILE = 1'b0,
        FORWARD  = 1'b1
    } fwrd_mux;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [PW-1:0]   src1_preg;
        logic [PW-1:0]   src2_preg;
        logic [PW-1:0]   dst_preg;
    } disp_packet_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [PW-1:0]   src1_preg;
        logic [PW-1:0]   src2_preg;
        logic [PW-1:0]   dst_preg;
        logic [XLEN-1:0] src1_val;
        logic [XLEN-1:0] src2_val;
        logic            alu_en;
    } exec_packet_t;

    typedef struct packed {
        disp_packet_t pkt;
        logic         vld;
        logic         src1_rdy;
        logic         src2_rdy;
    } rs_entry_t;

    // age[r][c] = 1 means entry r is older than entry c
    typedef logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] age_mat_t;

    function automatic logic wb_hit(
        input logic [PW-1:0]               preg,
        input logic [NUM_FUS-1:0]          wb_v,
        input logic [NUM_FUS-1:0][PW-1:0]  wb_p
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_FUS; k++) begin
            if (wb_v[k] && (wb_p[k] == preg)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Register-read fills the operand values later; the scheduler only routes the uop.
    function automatic exec_packet_t to_exec(input disp_packet_t d);
        exec_packet_t e;
        e.pc        = d.pc;
        e.opcode    = d.opcode;
        e.src1_preg = d.src1_preg;
        e.src2_preg = d.src2_preg;
        e.dst_preg  = d.dst_preg;
        e.src1_val  = '0;
        e.src2_val  = '0;
        e.alu_en    = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Combinational oldest-first selector over an age matrix, plus the matrix
// update applied when a new entry is allocated.
module rs_age_select
    import rs_issue_scheduler_pkg::*;
(
    input  age_mat_t                age,
    input  logic [RS_ENTRIES-1:0]   cand,
    input  logic                    alloc_en,
    input  logic [RS_IDX_W-1:0]     alloc_idx,
    output logic [RS_ENTRIES-1:0]   grant,
    output logic                    any_grant,
    output age_mat_t                age_next
);

    // New entry is younger than everyone: its row clears, its column sets.
    function automatic age_mat_t age_insert(input age_mat_t a, input logic [RS_IDX_W-1:0] idx);
        age_mat_t r;
        r = a;
        for (int row = 0; row < RS_ENTRIES; row++) begin
            for (int col = 0; col < RS_ENTRIES; col++) begin
                if (RS_IDX_W'(row) == idx) begin
                    r[row][col] = 1'b0;
                end else if (RS_IDX_W'(col) == idx) begin
                    r[row][col] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    logic [RS_ENTRIES-1:0] older_col [RS_ENTRIES];

    generate
        for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_grant
            for (genvar gj = 0; gj < RS_ENTRIES; gj++) begin : g_col
                assign older_col[gi][gj] = age[gj][gi];
            end
            // Granted only if no other candidate is older than this one.
            assign grant[gi] = cand[gi] && ~|(cand & older_col[gi]);
        end
    endgenerate

    assign any_grant = |grant;
    assign age_next  = alloc_en ? age_insert(age, alloc_idx) : age;

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station scheduler: buffers dispatched uops, wakes sources on
// writeback tags, issues the oldest ready entry. Macro: RS_WAKEUP_BYPASS_EN.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  disp_packet_t                disp_pkt,
    input  logic                        disp_src1_rdy,
    input  logic                        disp_src2_rdy,
    input  logic [NUM_FUS-1:0]          wb_valid,
    input  logic [NUM_FUS-1:0][PW-1:0]  wb_preg,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output exec_packet_t                iss_pkt,
    output fwrd_mux                     iss_src1_sel,
    output fwrd_mux                     iss_src2_sel,
    output logic [RS_CNT_W-1:0]         rs_count
);

    rs_entry_t             entry_reg [RS_ENTRIES];
    age_mat_t              age_reg;
    age_mat_t              age_next;
    logic                  iss_valid_reg;
    exec_packet_t          iss_pkt_reg;
    fwrd_mux               src1_sel_reg;
    fwrd_mux               src2_sel_reg;
    logic [RS_CNT_W-1:0]   count_reg;

    logic [RS_ENTRIES-1:0] vld_vec;
    logic [RS_ENTRIES-1:0] hit1;
    logic [RS_ENTRIES-1:0] hit2;
    logic [RS_ENTRIES-1:0] cand;
    logic [RS_ENTRIES-1:0] grant;
    logic                  any_grant;
    logic [RS_IDX_W-1:0]   grant_idx;
    logic [RS_IDX_W-1:0]   alloc_idx;
    logic                  alloc_en;
    logic                  load_en;
    logic                  disp_hit1;
    logic                  disp_hit2;
    fwrd_mux               sel1_next;
    fwrd_mux               sel2_next;

    generate
        for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_wake
            assign vld_vec[gi] = entry_reg[gi].vld;
            assign hit1[gi]    = wb_hit(entry_reg[gi].pkt.src1_preg, wb_valid, wb_preg);
            assign hit2[gi]    = wb_hit(entry_reg[gi].pkt.src2_preg, wb_valid, wb_preg);
`ifdef RS_WAKEUP_BYPASS_EN
            assign cand[gi] = entry_reg[gi].vld
                            && (entry_reg[gi].src1_rdy || hit1[gi])
                            && (entry_reg[gi].src2_rdy || hit2[gi]);
`else
            assign cand[gi] = entry_reg[gi].vld && entry_reg[gi].src1_rdy && entry_reg[gi].src2_rdy;
`endif
        end
    endgenerate

    rs_age_select u_age_select (
        .age       (age_reg),
        .cand      (cand),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .grant     (grant),
        .any_grant (any_grant),
        .age_next  (age_next)
    );

    // Free-slot view is registered, so a slot vacated by this cycle's issue stays unused.
    assign disp_ready = (count_reg < RS_CNT_W'(RS_ENTRIES)) && !rst;
    assign alloc_en   = disp_valid && disp_ready;
    assign load_en    = (!iss_valid_reg || iss_ready) && any_grant;
    assign disp_hit1  = wb_hit(disp_pkt.src1_preg, wb_valid, wb_preg);
    assign disp_hit2  = wb_hit(disp_pkt.src2_preg, wb_valid, wb_preg);

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!vld_vec[i]) begin
                alloc_idx = RS_IDX_W'(i);
            end
        end
        grant_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (grant[i]) begin
                grant_idx = RS_IDX_W'(i);
            end
        end
    end

    // A granted source not yet ready in registered state must have woken this cycle.
    always_comb begin
        sel1_next = REG_FILE;
        sel2_next = REG_FILE;
`ifdef RS_WAKEUP_BYPASS_EN
        if (!entry_reg[grant_idx].src1_rdy) sel1_next = FORWARD;
        if (!entry_reg[grant_idx].src2_rdy) sel2_next = FORWARD;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entry_reg[i] <= '0;
            end
            age_reg       <= '0;
            iss_valid_reg <= 1'b0;
            iss_pkt_reg   <= '0;
            src1_sel_reg  <= REG_FILE;
            src2_sel_reg  <= REG_FILE;
            count_reg     <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                entry_reg[i].vld      <= 1'b0;
                entry_reg[i].src1_rdy <= 1'b0;
                entry_reg[i].src2_rdy <= 1'b0;
            end
            iss_valid_reg <= 1'b0;
            count_reg     <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (entry_reg[i].vld && hit1[i]) entry_reg[i].src1_rdy <= 1'b1;
                if (entry_reg[i].vld && hit2[i]) entry_reg[i].src2_rdy <= 1'b1;
                if (load_en && grant[i]) entry_reg[i].vld <= 1'b0;
            end
            if (alloc_en) begin
                entry_reg[alloc_idx].pkt      <= disp_pkt;
                entry_reg[alloc_idx].vld      <= 1'b1;
                entry_reg[alloc_idx].src1_rdy <= disp_src1_rdy || disp_hit1;
                entry_reg[alloc_idx].src2_rdy <= disp_src2_rdy || disp_hit2;
            end
            age_reg <= age_next;
            if (load_en) begin
                iss_valid_reg <= 1'b1;
                iss_pkt_reg   <= to_exec(entry_reg[grant_idx].pkt);
                src1_sel_reg  <= sel1_next;
                src2_sel_reg  <= sel2_next;
            end else if (iss_ready) begin
                iss_valid_reg <= 1'b0;
            end
            count_reg <= count_reg + RS_CNT_W'(alloc_en) - RS_CNT_W'(load_en);
        end
    end

    assign iss_valid    = iss_valid_reg;
    assign iss_pkt      = iss_pkt_reg;
    assign iss_src1_sel = src1_sel_reg;
    assign iss_src2_sel = src2_sel_reg;
    assign rs_count     = count_reg;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issues are queued at
// dispatch/wakeup time and popped when the issue port hands off a uop.
module tb_rs_issue_scheduler;
    import rs_issue_scheduler_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        flush;
    logic                        disp_valid;
    logic                        disp_ready;
    disp_packet_t                disp_pkt;
    logic                        disp_src1_rdy;
    logic                        disp_src2_rdy;
    logic [NUM_FUS-1:0]          wb_valid;
    logic [NUM_FUS-1:0][PW-1:0]  wb_preg;
    logic                        iss_valid;
    logic                        iss_ready;
    exec_packet_t                iss_pkt;
    fwrd_mux                     iss_src1_sel;
    fwrd_mux                     iss_src2_sel;
    logic [RS_CNT_W-1:0]         rs_count;

    rs_issue_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_pkt      (disp_pkt),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .wb_valid      (wb_valid),
        .wb_preg       (wb_preg),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_pkt       (iss_pkt),
        .iss_src1_sel  (iss_src1_sel),
        .iss_src2_sel  (iss_src2_sel),
        .rs_count      (rs_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [PW-1:0] dst;
        fwrd_mux       sel1;
        fwrd_mux       sel2;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [31:0] pc, input logic [PW-1:0] s1, input logic [PW-1:0] s2,
                              input logic [PW-1:0] d, input logic r1, input logic r2);
        disp_valid         = 1'b1;
        disp_pkt.pc        = pc;
        disp_pkt.opcode    = 7'h33;
        disp_pkt.src1_preg = s1;
        disp_pkt.src2_preg = s2;
        disp_pkt.dst_preg  = d;
        disp_src1_rdy      = r1;
        disp_src2_rdy      = r2;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [PW-1:0] d);
        exp_t e;
        e.pc   = pc;
        e.dst  = d;
        e.sel1 = REG_FILE;
        e.sel2 = REG_FILE;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!iss_valid && rs_count == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check_eq(tag, done, 1'b1);
    endtask

    // Issue-port monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && iss_valid && iss_ready) begin
            $display("[TB] issue pc=0x%0h dst=%0d sel1=%0d sel2=%0d",
                     iss_pkt.pc, iss_pkt.dst_preg, iss_src1_sel, iss_src2_sel);
            check_eq("issue_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("issue_pc", iss_pkt.pc, e.pc);
                check_eq("issue_dst", iss_pkt.dst_preg, e.dst);
                check_eq("issue_sel1", iss_src1_sel, e.sel1);
                check_eq("issue_sel2", iss_src2_sel, e.sel2);
                check_eq("issue_alu_en", iss_pkt.alu_en, 1'b1);
                check_eq("issue_src_vals", {iss_pkt.src1_val, iss_pkt.src2_val}, 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_pkt = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        wb_valid = '0; wb_preg = '0; iss_ready = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check_eq("rst_iss_valid", iss_valid, 1'b0);
        check_eq("rst_rs_count", rs_count, 0);
        check_eq("rst_disp_ready", disp_ready, 1'b0);
        check_eq("rst_iss_pkt_zero", 64'(iss_pkt == '0), 1);
        rst = 1'b0;
        iss_ready = 1'b1;
        tick();
        check_eq("post_rst_disp_ready", disp_ready, 1'b1);

        // Single ready uop: allocate, then issue one edge later
        drive_disp(32'h100, 6'd1, 6'd2, 6'd5, 1'b1, 1'b1);
        push_exp(32'h100, 6'd5);
        tick();
        disp_valid = 1'b0;
        check_eq("t1_count_after_disp", rs_count, 1);
        check_eq("t1_not_yet_valid", iss_valid, 1'b0);
        tick();
        check_eq("t1_iss_valid", iss_valid, 1'b1);
        check_eq("t1_pc", iss_pkt.pc, 32'h100);
        check_eq("t1_count_after_issue", rs_count, 0);
        tick();
        check_eq("t1_iss_drop", iss_valid, 1'b0);

        // Fill all entries with src1 pending, keep offering
        for (int i = 0; i < 4; i++) begin
            drive_disp(32'h200 + 32'(4 * i), PW'(10 + i), 6'd40, PW'(20 + i), 1'b0, 1'b1);
            tick();
        end
        check_eq("t2_full_count", rs_count, 4);
        check_eq("t2_full_ready", disp_ready, 1'b0);
        drive_disp(32'h2F0, 6'd50, 6'd51, 6'd52, 1'b1, 1'b1);
        tick();
        check_eq("t2_full_ignored", rs_count, 4);
        disp_valid = 1'b0;
        wb_valid = 4'b0001;
        wb_preg[0] = 6'd12;
        push_exp(32'h208, 6'd22);
        tick();
        wb_valid = '0;
        check_eq("t2_wake_no_issue_yet", iss_valid, 1'b0);
        check_eq("t2_still_full", disp_ready, 1'b0);
        tick();
        check_eq("t2_entry2_issued", iss_valid, 1'b1);
        check_eq("t2_entry2_pc", iss_pkt.pc, 32'h208);
        check_eq("t2_count_3", rs_count, 3);
        check_eq("t2_ready_again", disp_ready, 1'b1);
        wb_valid = 4'b0111;
        wb_preg[0] = 6'd10; wb_preg[1] = 6'd11; wb_preg[2] = 6'd13;
        push_exp(32'h200, 6'd20);
        push_exp(32'h204, 6'd21);
        push_exp(32'h20C, 6'd23);
        tick();
        wb_valid = '0;
        drain("t2_drain");

        // Older A held at the issue port while B waits behind it
        iss_ready = 1'b0;
        drive_disp(32'h300, 6'd1, 6'd2, 6'd30, 1'b1, 1'b1);
        push_exp(32'h300, 6'd30);
        tick();
        drive_disp(32'h304, 6'd3, 6'd4, 6'd31, 1'b1, 1'b1);
        push_exp(32'h304, 6'd31);
        tick();
        disp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_eq("t3_hold_valid", iss_valid, 1'b1);
            check_eq("t3_hold_pc", iss_pkt.pc, 32'h300);
            tick();
        end
        check_eq("t3_b_waiting", rs_count, 1);
        iss_ready = 1'b1;
        tick();
        check_eq("t3_b_next", iss_pkt.pc, 32'h304);
        check_eq("t3_b_valid", iss_valid, 1'b1);
        tick();
        check_eq("t3_empty", iss_valid, 1'b0);

        // Dispatch-cycle wakeup of src2
        drive_disp(32'h400, 6'd3, 6'd17, 6'd44, 1'b1, 1'b0);
        wb_valid = 4'b1000;
        wb_preg[3] = 6'd17;
        push_exp(32'h400, 6'd44);
        tick();
        disp_valid = 1'b0;
        wb_valid = '0;
        check_eq("t4_not_yet", iss_valid, 1'b0);
        check_eq("t4_count", rs_count, 1);
        tick();
        check_eq("t4_issued", iss_valid, 1'b1);
        check_eq("t4_pc", iss_pkt.pc, 32'h400);
        drain("t4_drain");

        // Flush beats a same-cycle dispatch
        iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_disp(32'h500 + 32'(4 * i), 6'd1, 6'd2, PW'(i), 1'b1, 1'b1);
            tick();
        end
        disp_valid = 1'b0;
        check_eq("t5_pre_count", rs_count, 3);
        check_eq("t5_pre_valid", iss_valid, 1'b1);
        flush = 1'b1;
        drive_disp(32'h5F0, 6'd1, 6'd2, 6'd9, 1'b1, 1'b1);
        tick();
        flush = 1'b0;
        disp_valid = 1'b0;
        check_eq("t5_iss_cleared", iss_valid, 1'b0);
        check_eq("t5_count_zero", rs_count, 0);
        iss_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("t5_nothing_alloc", rs_count, 0);
        check_eq("t5_nothing_issued", iss_valid, 1'b0);

        // Reset mid-stream, then resume
        iss_ready = 1'b0;
        drive_disp(32'h600, 6'd1, 6'd2, 6'd60, 1'b1, 1'b1);
        tick();
        drive_disp(32'h604, 6'd1, 6'd2, 6'd61, 1'b1, 1'b1);
        tick();
        disp_valid = 1'b0;
        tick();
        check_eq("t6_pre_valid", iss_valid, 1'b1);
        check_eq("t6_pre_count", rs_count, 1);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_valid", iss_valid, 1'b0);
        check_eq("t6_rst_count", rs_count, 0);
        check_eq("t6_rst_ready", disp_ready, 1'b0);
        check_eq("t6_rst_pkt_zero", 64'(iss_pkt == '0), 1);
        check_eq("t6_rst_sel1", iss_src1_sel, REG_FILE);
        check_eq("t6_rst_sel2", iss_src2_sel, REG_FILE);
        tick();
        rst = 1'b0;
        iss_ready = 1'b1;
        drive_disp(32'h610, 6'd7, 6'd8, 6'd62, 1'b1, 1'b1);
        push_exp(32'h610, 6'd62);
        tick();
        disp_valid = 1'b0;
        tick();
        check_eq("t6_resume_valid", iss_valid, 1'b1);
        check_eq("t6_resume_pc", iss_pkt.pc, 32'h610);
        drain("t6_drain");
        check_eq("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
